mealy_fsm: RTL and testbench

- Overlapping serial sequence detector with Mealy-type outputs, driven by a 1-bit input stream sampled on each rising clock edge.
- y1 flags that the current bit completes "11" (two consecutive ones).
- y2 flags that the current bit completes "110".
- Used as a small control/pattern-detect leaf block; outputs are combinational functions of the registered state and the live input.

---
 rtl/mealy_fsm_pkg.sv | 14 +
 rtl/mealy_fsm.sv | 56 +++++
 tb/tb_mealy_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mealy_fsm_pkg.sv
// Shared definitions for the overlapping "11" / "110" Mealy sequence detector.
// IDLE must stay at 2'b00 so that the reset state is the all-zero encoding.
package mealy_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ZERO = 2'b01,
    ONE  = 2'b10,
    ONES = 2'b11
  } state_e;

  localparam state_e RESET_STATE = IDLE;

endpackage : mealy_fsm_pkg

// File: rtl/mealy_fsm.sv
// Overlapping serial detector: y1 marks the bit completing "11", y2 the bit completing "110".
// Outputs are Mealy-style, combinational from the state register and the live input.
module mealy_fsm
  import mealy_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y1,
  output logic y2
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RESET_STATE;
    case (state_q)
      IDLE:    state_d = x ? ONE  : ZERO;
      ZERO:    state_d = x ? ONE  : ZERO;
      ONE:     state_d = x ? ONES : ZERO;
      ONES:    state_d = x ? ONES : ZERO;
      default: state_d = RESET_STATE;
    endcase
  end

  // Gating on reset keeps both outputs at 0 even while x is X/Z during reset.
  always_comb begin
    y1 = 1'b0;
    y2 = 1'b0;
    if (!reset) begin
      case (state_q)
        ONE: begin
          y1 = x;
        end
        ONES: begin
          y1 = x;
          y2 = !x;
        end
        default: begin
          y1 = 1'b0;
          y2 = 1'b0;
        end
      endcase
    end
  end

endmodule : mealy_fsm

// File: tb/tb_mealy_fsm.sv
// Directed and random bench for mealy_fsm; expected {y1,y2} pairs are queued
// when a bit is driven and popped just before the edge that samples it.
module tb_mealy_fsm;
  import mealy_fsm_pkg::*;

  logic clk;
  logic reset;
  logic x;
  logic y1;
  logic y2;

  logic [1:0] exp_q[$];
  int n_checks;
  int n_errors;
  int run_model;

  mealy_fsm dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y1    (y1),
    .y2    (y2)
  );

  // Clock: posedges at 10, 30, 50, ...; inputs change on negedges.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_pop(input string tag);
    logic [1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, got y1y2=%b", tag, {y1, y2});
    end else begin
      e = exp_q.pop_front();
      assert ({y1, y2} === e) else begin
        n_errors++;
        $error("FAIL %s: y1y2 got %b expected %b", tag, {y1, y2}, e);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic e1, input logic e2);
    exp_q.push_back({e1, e2});
    check_pop(tag);
  endtask

  task automatic check_state(input string tag, input state_e exp_s);
    n_checks++;
    assert (dut.state_q === exp_s) else begin
      n_errors++;
      $error("FAIL %s: state got %b expected %b", tag, dut.state_q, exp_s);
    end
  endtask

  // Drive one serial bit on the negedge and check the outputs it produces in that cycle.
  task automatic drive_bit(input string tag, input logic xv, input logic e1, input logic e2);
    @(negedge clk);
    x = xv;
    exp_q.push_back({e1, e2});
    #2;
    check_pop(tag);
  endtask

  initial begin
    logic [11:0] seq4;
    logic [11:0] y1_4;
    logic [11:0] y2_4;
    logic [4:0]  seq5;
    logic        rb;
    logic        e1;
    logic        e2;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    x = 1'b1;

    // 1: reset holds outputs low for any x, then release into ZERO.
    #3;
    expect_now("rst_x1", 1'b0, 1'b0);
    x = 1'b0;
    #1;
    expect_now("rst_x0", 1'b0, 1'b0);
    x = 1'bx;
    #1;
    expect_now("rst_xx", 1'b0, 1'b0);
    check_state("rst_state", IDLE);
    x = 1'b0;
    reset = 1'b0;
    #1;
    expect_now("rel_x0", 1'b0, 1'b0);
    drive_bit("t1_b0", 1'b0, 1'b0, 1'b0);
    drive_bit("t1_b1", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_state("t1_zero", ZERO);

    // 2: "11" from ZERO.
    drive_bit("t2_b0", 1'b1, 1'b0, 1'b0);
    drive_bit("t2_b1", 1'b1, 1'b1, 1'b0);

    // 3: leave ONES (y2), then a clean 1,1,0.
    drive_bit("t3_pre", 1'b0, 1'b0, 1'b1);
    drive_bit("t3_b0", 1'b1, 1'b0, 1'b0);
    drive_bit("t3_b1", 1'b1, 1'b1, 1'b0);
    drive_bit("t3_b2", 1'b0, 1'b0, 1'b1);
    drive_bit("t3_b3", 1'b0, 1'b0, 1'b0);

    // 4: overlapping runs; index 11 is the first bit driven.
    seq4 = 12'b0011_0011_1100;
    y1_4 = 12'b0001_0001_1100;
    y2_4 = 12'b0000_1000_0010;
    for (int i = 11; i >= 0; i--) begin
      drive_bit($sformatf("t4_c%0d", 12 - i), seq4[i], y1_4[i], y2_4[i]);
    end

    // 5: alternating bits never complete either pattern.
    seq5 = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      drive_bit($sformatf("t5_c%0d", 5 - i), seq5[i], 1'b0, 1'b0);
    end

    // 6: reach ONES, toggle x within the cycle, then an async reset pulse.
    drive_bit("t6_ones", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    x = 1'b1;
    #1;
    expect_now("t6_mid_x1", 1'b1, 1'b0);
    x = 1'b0;
    #1;
    expect_now("t6_mid_x0", 1'b0, 1'b1);
    x = 1'b1;
    #1;
    expect_now("t6_mid_x1b", 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    expect_now("t6_async_rst", 1'b0, 1'b0);
    check_state("t6_rst_state", IDLE);
    reset = 1'b0;
    #1;
    expect_now("t6_after_rel", 1'b0, 1'b0);
    drive_bit("t6_second1", 1'b1, 1'b1, 1'b0);

    // Random stream against a trailing-ones count model (state is ONES here).
    run_model = 2;
    for (int i = 0; i < 40; i++) begin
      rb = 1'($urandom_range(0, 1));
      e1 = rb && (run_model >= 1);
      e2 = !rb && (run_model >= 2);
      drive_bit($sformatf("rnd_%0d", i), rb, e1, e2);
      run_model = rb ? ((run_model < 2) ? run_model + 1 : 2) : 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mealy_fsm
